dm_responder: RTL
=================

Name: dm_responder

Overview:
- Memory-side responder for the CPU data-memory port: accepts load/store requests over a valid/ready handshake and answers after a fixed, parameterised latency.
- Supports word, halfword and byte accesses with sign or zero extension on loads; little-endian byte lanes.
- Sits between the datapath's memory-access stage and the word-organised data RAM; replaces the zero-latency DM once the core is pipelined.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words of storage (12 KiB).
- ADDR_W, 12, word-index width; must satisfy 2^ADDR_W >= DEPTH_WORDS.
- LATENCY, 2, cycles from request handshake to rsp_valid rising; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 word, 01 halfword, 10 byte, 11 illegal.
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_pc  input  32  PC of the issuing instruction; used for the write log.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  misaligned, illegal-size or out-of-range access.

Behaviour:
- States: IDLE, BUSY, RESP. req_ready = (state == IDLE) while reset is deasserted; 0 while reset is asserted.
- IDLE: on req_valid && req_ready, latch every req_* field and load the counter with LATENCY-1. Go to BUSY, or go directly to RESP if LATENCY == 1.
- BUSY: decrement the counter each cycle; at 0, go to RESP. rsp_valid rises exactly LATENCY cycles after the accepting edge.
- Commit edge (the edge entering RESP):
  - Loads sample the array here; loads see all earlier committed stores.
  - Stores write the enabled lanes here.
  - rsp_rdata and rsp_err are registered here.
- RESP: rsp_valid = 1; all rsp_* held stable until rsp_valid && rsp_ready, then go to IDLE. No same-cycle re-accept; the minimum request spacing is LATENCY+1 cycles.
- Word index = addr[ADDR_W+1:2].
- Lane selection:
  - Byte: lane addr[1:0].
  - Half: lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes.
- Errors (rsp_err = 1, no write, rsp_rdata = 0):
  - req_size == 11.
  - Half access with addr[0] == 1.
  - Word access with addr[1:0] != 0.
  - addr >= DEPTH_WORDS*4, including any nonzero upper address bits.
- Load extension: byte/half replicate bit 7/15 when req_signed = 1, else pad zeros. req_signed is ignored for word loads and for all stores.
- Reset (asynchronous, active-low):
  - State -> IDLE; rsp_valid, rsp_err, rsp_rdata -> 0; counter -> 0.
  - All array words -> 0.
  - A pending store that has not reached its commit edge is discarded.
  - A response held in RESP is dropped.
- Inputs are ignored outside the IDLE handshake. rsp_ready is ignored when rsp_valid = 0.

Optional Feature:
- Macro DM_WRITE_LOG_EN.
- Defined: on every committed store (non-error), print one line in the format "@%h: *%h <= %h" with latched PC, word-aligned byte address, and the full resulting 32-bit word. Prints only at the commit edge; errors and loads print nothing.
- Undefined: no $display, no simulation-only logic; identical cycle behaviour.

Test Plan:
- Reset held low then released -> req_ready = 1, rsp_valid = 0. Word load at 0x0000 -> rsp_rdata = 0x00000000 at cycle T+2 (LATENCY = 2).
- Word store 0x12345678 to 0x0010, then byte load signed at 0x0013 -> 0x00000012. Half load signed at 0x0012 -> 0x00001234. Byte store 0xFF at 0x0011, then byte load signed at 0x0011 -> 0xFFFFFFFF; unsigned -> 0x000000FF; word load -> 0x1234FF78.
- Backpressure: hold rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready = 0 throughout. Raise rsp_ready -> req_ready = 1 on the next cycle.
- Errors, each giving rsp_err = 1, rsp_rdata = 0, and word 0x0010 unchanged:
  - Word store at 0x0012.
  - Half load at 0x0011.
  - req_size = 11.
  - Store at 0x3000 (DEPTH_WORDS = 3072).
- Reset mid-operation: issue a store to 0x0020, assert reset one cycle after acceptance, release -> rsp_valid never rises, and a word load at 0x0020 returns 0.
- With DM_WRITE_LOG_EN and PC 0x00003008: half store 0xBEEF at 0x0006 -> log "@00003008: *00000004 <= beef0000"; without the macro, no output.

Source files
------------

// File: rtl/dm_responder.sv
// Fixed-latency data-memory responder: word/half/byte load-store with a valid/ready handshake.
// Optional store trace enabled by defining DM_WRITE_LOG_EN.
module dm_responder #(
  parameter int DEPTH_WORDS = 3072,
  parameter int ADDR_W      = 12,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        commit;
  logic        accept;

  logic        lat_write_reg;
  logic [1:0]  lat_size_reg;
  logic        lat_signed_reg;
  logic [31:0] lat_addr_reg;
  logic [31:0] lat_wdata_reg;
  logic [31:0] lat_pc_reg;

  logic [31:0] rdata_reg;
  logic        err_reg;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_ready = (state_reg == IDLE) && reset;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state_reg == RESP);
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          cnt_next = 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_next = RESP;
            commit     = 1'b1;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_reg == 4'd0) begin
          state_next = RESP;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A single-cycle latency commits on the accepting edge, before the latches hold the request.
  logic        cur_write;
  logic [1:0]  cur_size;
  logic        cur_signed;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [31:0] cur_pc;

  assign cur_write  = (state_reg == IDLE) ? req_write  : lat_write_reg;
  assign cur_size   = (state_reg == IDLE) ? req_size   : lat_size_reg;
  assign cur_signed = (state_reg == IDLE) ? req_signed : lat_signed_reg;
  assign cur_addr   = (state_reg == IDLE) ? req_addr   : lat_addr_reg;
  assign cur_wdata  = (state_reg == IDLE) ? req_wdata  : lat_wdata_reg;
  assign cur_pc     = (state_reg == IDLE) ? req_pc     : lat_pc_reg;

  logic              in_range;
  logic              acc_err;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       old_word;
  logic [31:0]       shifted;
  logic [31:0]       load_val;
  logic [31:0]       wdata_rep;
  logic [31:0]       new_word;
  logic [3:0]        lane_en;

  assign in_range = cur_addr < 32'(DEPTH_WORDS * 4);
  assign acc_err  = (cur_size == 2'b11) ||
                    (cur_size == 2'b01 && cur_addr[0]) ||
                    (cur_size == 2'b00 && cur_addr[1:0] != 2'b00) ||
                    !in_range;
  assign word_idx = cur_addr[ADDR_W+1:2];
  assign old_word = in_range ? mem[word_idx] : 32'd0;
  assign shifted  = old_word >> {cur_addr[1:0], 3'b000};

  always_comb begin
    load_val = shifted;
    case (cur_size)
      2'b01:   load_val = {{16{cur_signed & shifted[15]}}, shifted[15:0]};
      2'b10:   load_val = {{24{cur_signed & shifted[7]}}, shifted[7:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    wdata_rep = cur_wdata;
    case (cur_size)
      2'b01:   wdata_rep = {2{cur_wdata[15:0]}};
      2'b10:   wdata_rep = {4{cur_wdata[7:0]}};
      default: wdata_rep = cur_wdata;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign lane_en[gi] = (cur_size == 2'b00) ||
                           (cur_size == 2'b01 && cur_addr[1] == LANE[1]) ||
                           (cur_size == 2'b10 && cur_addr[1:0] == LANE);
      assign new_word[gi*8 +: 8] = lane_en[gi] ? wdata_rep[gi*8 +: 8] : old_word[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= 4'd0;
      lat_write_reg  <= 1'b0;
      lat_size_reg   <= 2'b00;
      lat_signed_reg <= 1'b0;
      lat_addr_reg   <= 32'd0;
      lat_wdata_reg  <= 32'd0;
      lat_pc_reg     <= 32'd0;
      rdata_reg      <= 32'd0;
      err_reg        <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        lat_write_reg  <= req_write;
        lat_size_reg   <= req_size;
        lat_signed_reg <= req_signed;
        lat_addr_reg   <= req_addr;
        lat_wdata_reg  <= req_wdata;
        lat_pc_reg     <= req_pc;
      end
      if (commit) begin
        err_reg   <= acc_err;
        rdata_reg <= (acc_err || cur_write) ? 32'd0 : load_val;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
    end else if (commit && cur_write && !acc_err) begin
      mem[word_idx] <= new_word;
`ifdef DM_WRITE_LOG_EN
      $display("@%h: *%h <= %h", cur_pc, {cur_addr[31:2], 2'b00}, new_word);
`else
`endif
    end
  end

endmodule
